// File: rtl/boot_pkg.sv
// boot_pkg: shared FSM states and command bytes for mem_boot_loader.
// Optional feature macro: BOOT_CHECKSUM_EN adds the CHK state.
package boot_pkg;
   localparam logic [7:0] CMD_IMEM = 8'h49;
   localparam logic [7:0] CMD_DMEM = 8'h44;
   localparam logic [7:0] CMD_GO   = 8'h47;
   typedef enum logic [2:0] {
      IDLE,
      HDR,
      DATA,
`ifdef BOOT_CHECKSUM_EN
      CHK,
`endif
      RUN,
      ERR
   } state_t;
endpackage

// File: rtl/boot_word_asm.sv
// boot_word_asm: packs 4 accepted bytes into a little-endian 32-bit word.
// Ports: clk, reset (sync, active-high), clr (restart at byte 0), byte_valid/byte_in
// (accepted byte), word_valid (pulse with the 4th byte), word (assembled word).
module boot_word_asm (
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic        word_valid,
   output logic [31:0] word
);
   logic [1:0]  cnt_q;
   logic [23:0] sh_q;
   // Bytes enter at the top so after three bytes sh_q = {b2, b1, b0}.
   always_ff @(posedge clk) begin
      if (reset || clr) cnt_q <= 2'd0;
      else if (byte_valid) cnt_q <= cnt_q + 2'd1;
      if (byte_valid) sh_q <= {byte_in, sh_q[23:8]};
   end
   assign word_valid = byte_valid && cnt_q == 2'd3;
   assign word = {byte_in, sh_q};
endmodule

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: byte-stream boot loader writing imem/dmem and releasing core reset on GO.
// Ports: clk, reset (sync, active-high); rx_data/rx_valid/rx_ready byte stream;
// imem_we/imem_addr/imem_wdata and dmem_we/dmem_addr/dmem_wdata write ports;
// core_reset to the core; busy (HDR/DATA), done (RUN), err (sticky error).
// Optional feature macro: BOOT_CHECKSUM_EN expects a mod-256 payload sum after each frame.
module mem_boot_loader
   import boot_pkg::*;
#(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic        core_reset,
   output logic        busy,
   output logic        done,
   output logic        err
);
   localparam state_t S_END =
`ifdef BOOT_CHECKSUM_EN
      CHK;
`else
      IDLE;
`endif
   state_t      state_q, state_d;
   logic        sel_q, sel_d;
   logic [1:0]  hcnt_q, hcnt_d;
   logic [15:0] base_q, base_d, cnt_q, cnt_d, idx_q, idx_d, n_hdr;
   logic        imem_we_q, imem_we_d, dmem_we_q, dmem_we_d;
   logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
   logic        rx_ready_q, core_reset_q, busy_q, done_q, err_q;
   logic [16:0] depth;
   logic        fire, word_valid;
   logic [31:0] word;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]  sum_q, sum_d;
`endif
   assign fire = rx_valid && rx_ready_q;
   boot_word_asm u_asm (
      .clk        (clk),
      .reset      (reset),
      .clr        (state_q != DATA),
      .byte_valid (fire && state_q == DATA),
      .byte_in    (rx_data),
      .word_valid (word_valid),
      .word       (word)
   );
   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      hcnt_d    = hcnt_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      imem_we_d = 1'b0;
      dmem_we_d = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
`ifdef BOOT_CHECKSUM_EN
      sum_d     = sum_q;
`endif
      n_hdr     = {rx_data, cnt_q[7:0]};
      depth     = sel_q ? 17'(IMEM_WORDS) : 17'(DMEM_WORDS);
      case (state_q)
         IDLE: if (fire) begin
            sel_d   = rx_data == CMD_IMEM;
            hcnt_d  = 2'd0;
`ifdef BOOT_CHECKSUM_EN
            sum_d   = 8'd0;
`endif
            state_d = (rx_data == CMD_IMEM || rx_data == CMD_DMEM) ? HDR :
                      rx_data == CMD_GO ? RUN : ERR;
         end
         HDR: if (fire) begin
            hcnt_d = hcnt_q + 2'd1;
            idx_d  = 16'd0;
            base_d = hcnt_q == 2'd0 ? {base_q[15:8], rx_data} :
                     hcnt_q == 2'd1 ? {rx_data, base_q[7:0]} : base_q;
            cnt_d  = hcnt_q == 2'd2 ? {cnt_q[15:8], rx_data} :
                     hcnt_q == 2'd3 ? n_hdr : cnt_q;
            // 17-bit sum so a base near 0xFFFF cannot wrap past the depth check.
            if (hcnt_q == 2'd3)
               state_d = ({1'b0, base_q} + {1'b0, n_hdr} > depth) ? ERR :
                         n_hdr == 16'd0 ? S_END : DATA;
         end
         DATA: if (fire) begin
`ifdef BOOT_CHECKSUM_EN
            sum_d = sum_q + rx_data;
`endif
            if (word_valid) begin
               imem_we_d = sel_q;
               dmem_we_d = !sel_q;
               addr_d    = {13'd0, {1'b0, base_q} + {1'b0, idx_q}, 2'b00};
               wdata_d   = word;
               idx_d     = idx_q + 16'd1;
               if (idx_q + 16'd1 == cnt_q) state_d = S_END;
            end
         end
`ifdef BOOT_CHECKSUM_EN
         CHK: if (fire) state_d = rx_data == sum_q ? IDLE : ERR;
`endif
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         sel_q        <= 1'b0;
         hcnt_q       <= 2'd0;
         base_q       <= 16'd0;
         cnt_q        <= 16'd0;
         idx_q        <= 16'd0;
         imem_we_q    <= 1'b0;
         dmem_we_q    <= 1'b0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rx_ready_q   <= 1'b1;
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         sum_q        <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         hcnt_q       <= hcnt_d;
         base_q       <= base_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         imem_we_q    <= imem_we_d;
         dmem_we_q    <= dmem_we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rx_ready_q   <= state_d != RUN && state_d != ERR;
         core_reset_q <= state_d != RUN;
         busy_q       <= state_d == HDR || state_d == DATA;
         done_q       <= state_d == RUN;
         err_q        <= state_d == ERR;
`ifdef BOOT_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end
   assign rx_ready   = rx_ready_q;
   assign imem_we    = imem_we_q;
   assign dmem_we    = dmem_we_q;
   assign imem_addr  = addr_q;
   assign dmem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign dmem_wdata = wdata_q;
   assign core_reset = core_reset_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
endmodule
